// File: rtl/rv_decode_pkg.sv
// Shared decode constants for the RV32I(+M) decode stage.
// Holds op codes, major opcodes and the decoded-bundle layout.
package rv_decode_pkg;

  localparam int OP_BITS  = 6;
  localparam int IMM_BITS = 32;
  localparam int REG_BITS = 5;

  localparam logic [OP_BITS-1:0] OP_ADD     = 6'd0;
  localparam logic [OP_BITS-1:0] OP_SUB     = 6'd1;
  localparam logic [OP_BITS-1:0] OP_XOR     = 6'd2;
  localparam logic [OP_BITS-1:0] OP_OR      = 6'd3;
  localparam logic [OP_BITS-1:0] OP_AND     = 6'd4;
  localparam logic [OP_BITS-1:0] OP_SLL     = 6'd5;
  localparam logic [OP_BITS-1:0] OP_SRL     = 6'd6;
  localparam logic [OP_BITS-1:0] OP_SRA     = 6'd7;
  localparam logic [OP_BITS-1:0] OP_SLT     = 6'd8;
  localparam logic [OP_BITS-1:0] OP_SLTU    = 6'd9;
  localparam logic [OP_BITS-1:0] OP_ADDI    = 6'd10;
  localparam logic [OP_BITS-1:0] OP_XORI    = 6'd11;
  localparam logic [OP_BITS-1:0] OP_ORI     = 6'd12;
  localparam logic [OP_BITS-1:0] OP_ANDI    = 6'd13;
  localparam logic [OP_BITS-1:0] OP_SLLI    = 6'd14;
  localparam logic [OP_BITS-1:0] OP_SRLI    = 6'd15;
  localparam logic [OP_BITS-1:0] OP_SRAI    = 6'd16;
  localparam logic [OP_BITS-1:0] OP_SLTI    = 6'd17;
  localparam logic [OP_BITS-1:0] OP_SLTIU   = 6'd18;
  localparam logic [OP_BITS-1:0] OP_LB      = 6'd19;
  localparam logic [OP_BITS-1:0] OP_LH      = 6'd20;
  localparam logic [OP_BITS-1:0] OP_LW      = 6'd21;
  localparam logic [OP_BITS-1:0] OP_LBU     = 6'd22;
  localparam logic [OP_BITS-1:0] OP_LHU     = 6'd23;
  localparam logic [OP_BITS-1:0] OP_SB      = 6'd24;
  localparam logic [OP_BITS-1:0] OP_SH      = 6'd25;
  localparam logic [OP_BITS-1:0] OP_SW      = 6'd26;
  localparam logic [OP_BITS-1:0] OP_BEQ     = 6'd27;
  localparam logic [OP_BITS-1:0] OP_BNE     = 6'd28;
  localparam logic [OP_BITS-1:0] OP_BLT     = 6'd29;
  localparam logic [OP_BITS-1:0] OP_BGE     = 6'd30;
  localparam logic [OP_BITS-1:0] OP_BLTU    = 6'd31;
  localparam logic [OP_BITS-1:0] OP_BGEU    = 6'd32;
  localparam logic [OP_BITS-1:0] OP_JAL     = 6'd33;
  localparam logic [OP_BITS-1:0] OP_LUI     = 6'd34;
  localparam logic [OP_BITS-1:0] OP_AUIPC   = 6'd35;
  localparam logic [OP_BITS-1:0] OP_JALR    = 6'd36;
  localparam logic [OP_BITS-1:0] OP_MUL     = 6'd37;
  localparam logic [OP_BITS-1:0] OP_ILLEGAL = 6'd63;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef struct packed {
    logic [OP_BITS-1:0]  op;
    logic [IMM_BITS-1:0] imm;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
    logic                rs1_en;
    logic                rs2_en;
    logic                rd_en;
    logic                illegal;
  } dec_t;

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master drives instructions in and accepts bundles; slave is the stage.
interface rv_decode_if
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 6
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [XLEN-1:0]     in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [OP_W-1:0]     out_op;
  logic [XLEN-1:0]     out_imm;
  logic [REG_BITS-1:0] out_rs1;
  logic [REG_BITS-1:0] out_rs2;
  logic [REG_BITS-1:0] out_rd;
  logic                out_rs1_en;
  logic                out_rs2_en;
  logic                out_rd_en;
  logic [XLEN-1:0]     out_pc;
  logic                out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_imm,
    input  out_rs1, out_rs2, out_rd,
    input  out_rs1_en, out_rs2_en, out_rd_en,
    input  out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_imm,
    output out_rs1, out_rs2, out_rd,
    output out_rs1_en, out_rs2_en, out_rd_en,
    output out_pc, out_illegal
  );
endinterface

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I(+M) decoder: instruction word to bundle.
// Any unrecognised encoding collapses to OP_ILLEGAL with all fields zero.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr,
  output dec_t        dec
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [IMM_BITS-1:0] imm_i, imm_s, imm_b;
  logic [IMM_BITS-1:0] imm_u, imm_j, imm_sh;
  logic [OP_BITS-1:0]  op;
  logic [IMM_BITS-1:0] imm;
  logic u1, u2, ud, ok;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    op  = OP_ILLEGAL;
    imm = '0;
    u1  = 1'b0;
    u2  = 1'b0;
    ud  = 1'b0;
    unique case (1'b1)
      (opc == OPC_OP): begin
        u1 = 1'b1; u2 = 1'b1; ud = 1'b1;
        if (f7 == F7_BASE) begin
          unique case (f3)
            3'b000: op = OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = OP_SRL;
            3'b110: op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op = OP_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          op = OP_SRA;
        end else if (ENABLE_M && f7 == F7_MD) begin
          op = OP_MUL + OP_BITS'(f3);
        end
      end
      (opc == OPC_OPIMM): begin
        u1 = 1'b1; ud = 1'b1; imm = imm_i;
        unique case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: begin
            imm = imm_sh;
            if (f7 == F7_BASE) op = OP_SLLI;
          end
          default: begin
            imm = imm_sh;
            if (f7 == F7_BASE) op = OP_SRLI;
            else if (f7 == F7_ALT) op = OP_SRAI;
          end
        endcase
      end
      (opc == OPC_LOAD): begin
        u1 = 1'b1; ud = 1'b1; imm = imm_i;
        unique case (f3)
          3'b000: op = OP_LB;
          3'b001: op = OP_LH;
          3'b010: op = OP_LW;
          3'b100: op = OP_LBU;
          3'b101: op = OP_LHU;
          default: op = OP_ILLEGAL;
        endcase
      end
      (opc == OPC_STORE): begin
        u1 = 1'b1; u2 = 1'b1; imm = imm_s;
        unique case (f3)
          3'b000: op = OP_SB;
          3'b001: op = OP_SH;
          3'b010: op = OP_SW;
          default: op = OP_ILLEGAL;
        endcase
      end
      (opc == OPC_BRANCH): begin
        u1 = 1'b1; u2 = 1'b1; imm = imm_b;
        unique case (f3)
          3'b000: op = OP_BEQ;
          3'b001: op = OP_BNE;
          3'b100: op = OP_BLT;
          3'b101: op = OP_BGE;
          3'b110: op = OP_BLTU;
          3'b111: op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
      end
      (opc == OPC_JAL): begin
        ud = 1'b1; imm = imm_j; op = OP_JAL;
      end
      (opc == OPC_JALR): begin
        u1 = 1'b1; ud = 1'b1; imm = imm_i;
        if (f3 == 3'b000) op = OP_JALR;
      end
      (opc == OPC_LUI): begin
        ud = 1'b1; imm = imm_u; op = OP_LUI;
      end
      (opc == OPC_AUIPC): begin
        ud = 1'b1; imm = imm_u; op = OP_AUIPC;
      end
      default: op = OP_ILLEGAL;
    endcase

    ok          = (op != OP_ILLEGAL);
    dec.op      = op;
    dec.illegal = !ok;
    dec.imm     = ok ? imm : '0;
    dec.rs1_en  = ok && u1;
    dec.rs2_en  = ok && u2;
    dec.rd_en   = ok && ud && (instr[11:7] != 5'd0);
    dec.rs1     = (ok && u1) ? instr[19:15] : '0;
    dec.rs2     = (ok && u2) ? instr[24:20] : '0;
    dec.rd      = (ok && ud) ? instr[11:7]  : '0;
  end
endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage with a two-entry skid buffer and flush.
// out_q is the presented bundle, skid_q catches one extra under stall.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int OP_W     = 6,
  parameter bit ENABLE_M = 1'b0
) (
  input logic       clk,
  input logic       rst_n,
  input logic       flush,
  rv_decode_if.slave bus
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]      state_q, state_d;
  dec_t            dec, out_q, skid_q;
  logic [XLEN-1:0] out_pc_q, skid_pc_q;
  logic            in_ready_q, out_valid;
  logic            in_acc, out_acc;
  logic            load_out, load_skid, promote;

  rv_decode_comb #(.ENABLE_M(ENABLE_M)) u_comb (
    .instr (bus.in_instr),
    .dec   (dec)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_acc    = bus.in_valid & in_ready_q;
  assign out_acc   = out_valid & bus.out_ready;

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    unique case (state_q)
      ST_EMPTY: if (in_acc) begin
        state_d  = ST_ONE;
        load_out = 1'b1;
      end
      ST_ONE: if (in_acc && out_acc) begin
        load_out = 1'b1;
      end else if (in_acc) begin
        state_d   = ST_TWO;
        load_skid = 1'b1;
      end else if (out_acc) begin
        state_d = ST_EMPTY;
      end
      ST_TWO: if (out_acc) begin
        state_d = ST_ONE;
        promote = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    // a redirect kills held entries and the word arriving this cycle
    if (flush) begin
      state_d   = ST_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      promote   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      out_pc_q   <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      if (load_out) begin
        out_q    <= dec;
        out_pc_q <= bus.in_pc;
      end else if (promote) begin
        out_q    <= skid_q;
        out_pc_q <= skid_pc_q;
      end
      if (load_skid) begin
        skid_q    <= dec;
        skid_pc_q <= bus.in_pc;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_op      = OP_W'(out_q.op);
  assign bus.out_imm     = XLEN'(out_q.imm);
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1_en  = out_q.rs1_en;
  assign bus.out_rs2_en  = out_q.rs2_en;
  assign bus.out_rd_en   = out_q.rd_en;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode, skid, flush and reset.
// Two instances share stimulus; one has the M extension enabled.
module tb_rv_decode_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  rv_decode_if #(.XLEN(32), .OP_W(6)) bm ();
  rv_decode_if #(.XLEN(32), .OP_W(6)) bn ();

  rv_decode_stage #(.XLEN(32), .OP_W(6), .ENABLE_M(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bm.slave)
  );

  rv_decode_stage #(.XLEN(32), .OP_W(6), .ENABLE_M(1'b0)) dut_nm (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bn.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc);
    bm.in_valid = v; bm.in_instr = ins; bm.in_pc = pc;
    bn.in_valid = v; bn.in_instr = ins; bn.in_pc = pc;
  endtask

  task automatic set_ready(input logic r);
    bm.out_ready = r;
    bn.out_ready = r;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] op,
                         input logic [31:0] imm, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(bm.out_valid), 32'd1);
    chk({tag, ".op"}, 32'(bm.out_op), 32'(op));
    chk({tag, ".imm"}, bm.out_imm, imm);
    chk({tag, ".pc"}, bm.out_pc, pc);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    set_ready(1'b1);
    step();
    step();
    chk("rst.valid", 32'(bm.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bm.in_ready), 32'd0);
    chk("rst.op", 32'(bm.out_op), 32'd0);
    chk("rst.imm", bm.out_imm, 32'd0);

    rst_n = 1'b1;
    step();
    chk("post_rst.in_ready", 32'(bm.in_ready), 32'd1);
    chk("post_rst.valid", 32'(bm.out_valid), 32'd0);

    // add x3,x1,x2
    drive(1'b1, 32'h002081B3, 32'h100);
    step();
    chk_out("add", 6'd0, 32'd0, 32'h100);
    chk("add.rs1", 32'(bm.out_rs1), 32'd1);
    chk("add.rs2", 32'(bm.out_rs2), 32'd2);
    chk("add.rd", 32'(bm.out_rd), 32'd3);
    chk("add.en", 32'({bm.out_rs1_en, bm.out_rs2_en, bm.out_rd_en}), 32'd7);
    chk("add.ill", 32'(bm.out_illegal), 32'd0);

    // addi x5,x0,-1
    drive(1'b1, 32'hFFF00293, 32'h104);
    step();
    chk_out("addi", 6'd10, 32'hFFFFFFFF, 32'h104);
    chk("addi.rs1", 32'(bm.out_rs1), 32'd0);
    chk("addi.rs1_en", 32'(bm.out_rs1_en), 32'd1);
    chk("addi.rd", 32'(bm.out_rd), 32'd5);
    chk("addi.rs2_en", 32'(bm.out_rs2_en), 32'd0);
    chk("addi.rs2", 32'(bm.out_rs2), 32'd0);

    // beq x1,x2,-4
    drive(1'b1, 32'hFE208EE3, 32'h108);
    step();
    chk_out("beq", 6'd27, 32'hFFFFFFFC, 32'h108);
    chk("beq.rd_en", 32'(bm.out_rd_en), 32'd0);
    chk("beq.rs", 32'({bm.out_rs1, bm.out_rs2}), 32'h22);

    // sw x2,8(x1)
    drive(1'b1, 32'h0020A423, 32'h10C);
    step();
    chk_out("sw", 6'd26, 32'd8, 32'h10C);
    chk("sw.rd_en", 32'(bm.out_rd_en), 32'd0);

    // lui x7,0x12345
    drive(1'b1, 32'h123453B7, 32'h110);
    step();
    chk_out("lui", 6'd34, 32'h12345000, 32'h110);
    chk("lui.rs1_en", 32'(bm.out_rs1_en), 32'd0);

    // srai x4,x1,3
    drive(1'b1, 32'h4030D213, 32'h114);
    step();
    chk_out("srai", 6'd16, 32'd3, 32'h114);

    // jal x1,8
    drive(1'b1, 32'h008000EF, 32'h118);
    step();
    chk_out("jal", 6'd33, 32'd8, 32'h118);
    chk("jal.rd", 32'(bm.out_rd), 32'd1);

    // mul x3,x1,x2
    drive(1'b1, 32'h022081B3, 32'h11C);
    step();
    chk_out("mul", 6'd37, 32'd0, 32'h11C);
    chk("mul.ill", 32'(bm.out_illegal), 32'd0);
    chk("mul_nm.op", 32'(bn.out_op), 32'd63);
    chk("mul_nm.ill", 32'(bn.out_illegal), 32'd1);
    chk("mul_nm.en", 32'({bn.out_rs1_en, bn.out_rs2_en, bn.out_rd_en}),
        32'd0);

    drive(1'b1, 32'h00000000, 32'h120);
    step();
    chk_out("zero", 6'd63, 32'd0, 32'h120);
    chk("zero.ill", 32'(bm.out_illegal), 32'd1);

    // load with reserved funct3 011
    drive(1'b1, 32'h00003003, 32'h124);
    step();
    chk("ld.ill", 32'(bm.out_illegal), 32'd1);
    chk("ld.en", 32'({bm.out_rs1_en, bm.out_rs2_en, bm.out_rd_en}), 32'd0);

    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("drain.valid", 32'(bm.out_valid), 32'd0);

    // backpressure: fill both entries, then drain
    set_ready(1'b0);
    drive(1'b1, 32'h00100093, 32'h200);
    step();
    chk("bp0.in_ready", 32'(bm.in_ready), 32'd1);
    drive(1'b1, 32'h00200113, 32'h204);
    step();
    chk("bp1.in_ready", 32'(bm.in_ready), 32'd0);
    chk("bp1.pc", bm.out_pc, 32'h200);
    drive(1'b1, 32'h00300193, 32'h208);
    step();
    chk("bp2.in_ready", 32'(bm.in_ready), 32'd0);
    chk_out("bp2.hold", 6'd10, 32'd1, 32'h200);
    set_ready(1'b1);
    step();
    chk_out("bp.o1", 6'd10, 32'd2, 32'h204);
    chk("bp.o1.in_ready", 32'(bm.in_ready), 32'd1);
    step();
    chk_out("bp.o2", 6'd10, 32'd3, 32'h208);
    drive(1'b1, 32'h00400213, 32'h20C);
    step();
    chk_out("bp.o3", 6'd10, 32'd4, 32'h20C);
    chk("bp.o3.rd", 32'(bm.out_rd), 32'd4);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("bp.end.valid", 32'(bm.out_valid), 32'd0);

    // flush in state TWO with a third word offered
    set_ready(1'b0);
    drive(1'b1, 32'h00100093, 32'h300);
    step();
    drive(1'b1, 32'h00200113, 32'h304);
    step();
    chk("fl.two.in_ready", 32'(bm.in_ready), 32'd0);
    drive(1'b1, 32'h00300193, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl.valid", 32'(bm.out_valid), 32'd0);
    chk("fl.in_ready", 32'(bm.in_ready), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    set_ready(1'b1);
    step();
    chk("fl.after1.valid", 32'(bm.out_valid), 32'd0);
    step();
    chk("fl.after2.valid", 32'(bm.out_valid), 32'd0);

    // reset mid-stream
    set_ready(1'b0);
    drive(1'b1, 32'hFFF00293, 32'h400);
    step();
    chk("mr.pre.valid", 32'(bm.out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mr.valid", 32'(bm.out_valid), 32'd0);
    chk("mr.op", 32'(bm.out_op), 32'd0);
    chk("mr.imm", bm.out_imm, 32'd0);
    chk("mr.pc", bm.out_pc, 32'd0);
    chk("mr.rd", 32'(bm.out_rd), 32'd0);
    chk("mr.in_ready", 32'(bm.in_ready), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("mr.rel.in_ready", 32'(bm.in_ready), 32'd1);
    chk("mr.rel.valid", 32'(bm.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
